// File: rtl/dmem_mmio.sv
// Data-side memory for the single-cycle core: word RAM plus a timer and a TX-only 8N1 UART.
// read_data is combinational from current state; all writes land at the clock edge.
module dmem_mmio #(
  parameter int unsigned DEPTH_WORDS  = 64,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        uart_tx,
  output logic        timer_irq
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [31:0] TIMER_COUNT_A  = 32'hFFFF_0000;
  localparam logic [31:0] TIMER_CMP_A    = 32'hFFFF_0004;
  localparam logic [31:0] TIMER_STATUS_A = 32'hFFFF_0008;
  localparam logic [31:0] UART_TXDATA_A  = 32'hFFFF_0010;
  localparam logic [31:0] UART_STATUS_A  = 32'hFFFF_0014;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [31:0]   word_addr;
  logic          ram_sel;
  logic [AW-1:0] ram_idx;
  logic          wr_count, wr_cmp, wr_status, wr_tx;

  logic [31:0] ram_q [DEPTH_WORDS];

  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        match_q, match_d;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          last_tick;
  logic          busy;

  // Address decode; the low two address bits never select anything
  assign word_addr = {addr[31:2], 2'b00};
  assign ram_sel   = (addr[31:AW+2] == '0);
  assign ram_idx   = addr[AW+1:2];
  assign wr_count  = mem_write && (word_addr == TIMER_COUNT_A);
  assign wr_cmp    = mem_write && (word_addr == TIMER_CMP_A);
  assign wr_status = mem_write && (word_addr == TIMER_STATUS_A);
  assign wr_tx     = mem_write && (word_addr == UART_TXDATA_A);

  assign busy      = (state_q != S_IDLE);
  assign uart_tx   = tx_q;
  assign timer_irq = match_q;

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (mem_write && ram_sel) ram_q[ram_idx] <= write_data;
  end

  // Timer: a compare hit on the same edge as a clear keeps the flag set
  always_comb begin
    count_d = wr_count ? write_data : count_q + 32'd1;
    cmp_d   = wr_cmp ? write_data : cmp_q;
    match_d = (count_q == cmp_q) || (match_q && !(wr_status && write_data[0]));
  end

  // UART next-state; each line level holds for CLKS_PER_BIT cycles
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    last_tick = (cnt_q == CW'(CLKS_PER_BIT - 1));
    if (state_q != S_IDLE) cnt_d = last_tick ? '0 : cnt_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (wr_tx) begin
          state_d = S_START;
          shift_d = write_data[7:0];
          cnt_d   = '0;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (last_tick) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (last_tick) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (last_tick) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      cmp_q   <= '1;
      match_q <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Side-effect-free read mux
  always_comb begin
    read_data = '0;
    if (ram_sel) begin
      read_data = ram_q[ram_idx];
    end else begin
      case (word_addr)
        TIMER_COUNT_A:  read_data = count_q;
        TIMER_CMP_A:    read_data = cmp_q;
        TIMER_STATUS_A: read_data = {31'd0, match_q};
        UART_STATUS_A:  read_data = {31'd0, busy};
        default:        read_data = '0;
      endcase
    end
  end

endmodule
